mem_access_stage: RTL

MEM stage of the 5-stage MIPS pipeline. It sits directly downstream of the EX-stage ALU. It takes the ALU result, using it as the load/store address or as a pass-through writeback value, and runs a req/ack transaction with data memory. It then aligns and extends load data and presents a registered MEM/WB result. While a memory transaction is outstanding it stalls upstream.

---
 rtl/mem_access_stage.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: ALU result -> data-memory req/ack transaction -> aligned, extended MEM/WB result.
// Latency: 1 cycle for pass-through ops and misalign flags; memory ops retire 1 cycle after dmem_ack (minimum 2).
// Backpressure: mem_ready is low for the whole outstanding transaction, and upstream stalls while it is low.
//
// Ports:
//   clk, rst_n                      pipeline clock and asynchronous active-low reset
//   ex_valid, ex_alu_res,           instruction from EX: address or pass-through value,
//   ex_store_data, ex_mem_op,       store data (rt), memory opcode,
//   ex_rd, ex_reg_write             destination register and its write enable
//   mem_ready                       stage can accept an instruction (decoded from state only)
//   dmem_req/we/addr/wdata/be       registered data-memory request, held stable until ack
//   dmem_ack, dmem_rdata            memory completion and load word
//   wb_valid/rd/reg_write/data      registered MEM/WB result, one-cycle pulse per instruction
//   misalign_exc                    one-cycle pulse when an access was squashed for misalignment

module mem_access_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_res,
    input  logic [31:0] ex_store_data,
    input  logic [3:0]  ex_mem_op,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        mem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        misalign_exc
);

    localparam logic [3:0] OP_LW  = 4'b0001;
    localparam logic [3:0] OP_LH  = 4'b0010;
    localparam logic [3:0] OP_LHU = 4'b0011;
    localparam logic [3:0] OP_LB  = 4'b0100;
    localparam logic [3:0] OP_LBU = 4'b0101;
    localparam logic [3:0] OP_SW  = 4'b0110;
    localparam logic [3:0] OP_SH  = 4'b0111;
    localparam logic [3:0] OP_SB  = 4'b1000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // EX-side decode
    logic        is_load;
    logic        is_store;
    logic        misaligned;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;

    // FSM control strobes
    logic        start_pass;
    logic        start_mem;
    logic        start_exc;
    logic        finish;

    // Context of the outstanding transaction
    logic [3:0]  op_q;
    logic [1:0]  lane_q;
    logic [4:0]  rd_q;
    logic        rw_q;
    logic        load_q;

    // Load alignment
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Upstream handshake depends on state only, so there is no combinational
    // path from ex_* or dmem_ack to mem_ready.
    assign mem_ready = (state == ST_IDLE);

    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        case (ex_mem_op)
            OP_LW: begin
                is_load    = 1'b1;
                misaligned = |ex_alu_res[1:0];
            end
            OP_LH, OP_LHU: begin
                is_load    = 1'b1;
                misaligned = ex_alu_res[0];
            end
            OP_LB, OP_LBU: begin
                is_load    = 1'b1;
            end
            OP_SW: begin
                is_store   = 1'b1;
                misaligned = |ex_alu_res[1:0];
            end
            OP_SH: begin
                is_store   = 1'b1;
                misaligned = ex_alu_res[0];
            end
            OP_SB: begin
                is_store   = 1'b1;
            end
            default: begin
                // unused codes behave as "no memory op"
            end
        endcase
    end

    // Store data is replicated across lanes so the memory only has to honour
    // byte enables; loads read the full word and align on return.
    always_comb begin
        st_wdata = 32'h0;
        st_be    = 4'b1111;
        case (ex_mem_op)
            OP_SW: begin
                st_wdata = ex_store_data;
                st_be    = 4'b1111;
            end
            OP_SH: begin
                st_wdata = {2{ex_store_data[15:0]}};
                st_be    = ex_alu_res[1] ? 4'b1100 : 4'b0011;
            end
            OP_SB: begin
                st_wdata = {4{ex_store_data[7:0]}};
                st_be    = 4'b0001 << ex_alu_res[1:0];
            end
            default: begin
                st_wdata = 32'h0;
                st_be    = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_pass = 1'b0;
        start_mem  = 1'b0;
        start_exc  = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (is_load || is_store) begin
                        if (misaligned) begin
                            start_exc = 1'b1;
                        end else begin
                            start_mem = 1'b1;
                            state_nxt = ST_WAIT;
                        end
                    end else begin
                        start_pass = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    finish    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign load_q = (op_q >= OP_LW) && (op_q <= OP_LBU);

    always_comb begin
        ld_byte = 8'h0;
        case (lane_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
    end

    // Halfwords are always lane 0 or lane 2 here; odd lanes were rejected as misaligned.
    assign ld_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        ld_data = 32'h0;
        case (op_q)
            OP_LW:   ld_data = dmem_rdata;
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'h0, ld_half};
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'h0, ld_byte};
            default: ld_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'h0;
            dmem_wdata   <= 32'h0;
            dmem_be      <= 4'b0000;
            op_q         <= 4'b0000;
            lane_q       <= 2'b00;
            rd_q         <= 5'd0;
            rw_q         <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_reg_write <= 1'b0;
            wb_data      <= 32'h0;
            misalign_exc <= 1'b0;
        end else begin
            // result strobes are single-cycle pulses
            wb_valid     <= 1'b0;
            misalign_exc <= 1'b0;

            if (start_pass) begin
                wb_valid     <= 1'b1;
                wb_data      <= ex_alu_res;
                wb_rd        <= ex_rd;
                wb_reg_write <= ex_reg_write;
            end

            if (start_exc) begin
                misalign_exc <= 1'b1;
            end

            if (start_mem) begin
                dmem_req   <= 1'b1;
                dmem_we    <= is_store;
                dmem_addr  <= {ex_alu_res[31:2], 2'b00};
                dmem_wdata <= st_wdata;
                dmem_be    <= st_be;
                op_q       <= ex_mem_op;
                lane_q     <= ex_alu_res[1:0];
                rd_q       <= ex_rd;
                rw_q       <= ex_reg_write;
            end

            // Request fields other than req are left as-is after completion;
            // they are only meaningful while dmem_req is high.
            if (finish) begin
                dmem_req     <= 1'b0;
                wb_valid     <= 1'b1;
                wb_rd        <= rd_q;
                wb_reg_write <= load_q & rw_q;
                wb_data      <= load_q ? ld_data : 32'h0;
            end
        end
    end

endmodule
